// File: rtl/bcd_dec_arbiter.sv
// Round-robin arbiter sharing one BCD-to-decimal decoder across requesters.
// Define BCD_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module bcd_dec_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_digit,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [9:0]         rsp_onehot,
    output logic               rsp_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e           state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [9:0]      onehot_q, onehot_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] base;
    logic [ID_W-1:0] win;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic [3:0]      digit;
    logic [9:0]      dec;

`ifdef BCD_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (int'(win) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // First valid requester at or after base, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(base) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign accept     = !rst && can_accept && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = N_REQ'(1) << win;
        end
    end

    assign digit = req_digit[4*int'(win) +: 4];

    always_comb begin
        dec = '0;
        unique case (digit)
            4'd0: dec = 10'b00_0000_0001;
            4'd1: dec = 10'b00_0000_0010;
            4'd2: dec = 10'b00_0000_0100;
            4'd3: dec = 10'b00_0000_1000;
            4'd4: dec = 10'b00_0001_0000;
            4'd5: dec = 10'b00_0010_0000;
            4'd6: dec = 10'b00_0100_0000;
            4'd7: dec = 10'b00_1000_0000;
            4'd8: dec = 10'b01_0000_0000;
            4'd9: dec = 10'b10_0000_0000;
            default: dec = '0;
        endcase
    end

    // Accept wins over drain, so a simultaneous drain+accept stays FULL.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        onehot_d = onehot_q;
        err_d    = err_q;
        if (accept) begin
            state_d  = FULL;
            id_d     = win;
            onehot_d = dec;
            err_d    = (digit > 4'd9);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            id_q     <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = id_q;
    assign rsp_onehot = onehot_q;
    assign rsp_err    = err_q;

endmodule
